// File: rtl/multiport_register_file.sv
// Parameterised register file: NRP combinational read ports, two write ports,
// optional hardwired x0 and write-to-read bypass, with a zeroing sweep after reset or clear.
module multiport_register_file #(
  parameter int XLEN     = 64,
  parameter int NREGS    = 32,
  parameter int NRP      = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear_req,
  input  logic [NRP*$clog2(NREGS)-1:0] rs,
  output logic [NRP*XLEN-1:0]   ReadData,
  input  logic [1:0]            RegWrite,
  input  logic [2*$clog2(NREGS)-1:0]   rd,
  input  logic [2*XLEN-1:0]     WriteData,
  output logic                  ready
);

  localparam int AW = $clog2(NREGS);

  typedef enum logic {CLEAR, READY} state_t;

  state_t          state, state_n;
  logic [AW-1:0]   cnt, cnt_n;
  logic            ready_q;
  logic [XLEN-1:0] regs [NREGS];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= CLEAR;
      cnt     <= '0;
      ready_q <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      ready_q <= (state_n == READY);
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    case (state)
      CLEAR: begin
        cnt_n = cnt + 1'b1;
        if (cnt == AW'(NREGS - 1)) state_n = READY;
      end
      READY: begin
        if (clear_req) begin
          state_n = CLEAR;
          cnt_n   = '0;
        end
      end
      default: state_n = CLEAR;
    endcase
  end

  assign ready = ready_q;

  // Array has no reset; the sweep zeroes it. Loop order lets port 1 win on equal addresses.
  always_ff @(posedge clk) begin
    if (state == CLEAR) begin
      regs[cnt] <= '0;
    end else begin
      for (int unsigned w = 0; w < 2; w++) begin
        if (RegWrite[w] && !(ZERO_REG != 0 && rd[w*AW +: AW] == '0))
          regs[rd[w*AW +: AW]] <= WriteData[w*XLEN +: XLEN];
      end
    end
  end

  for (genvar k = 0; k < NRP; k++) begin : g_rd
    logic [AW-1:0]   a;
    logic [XLEN-1:0] d;

    assign a = rs[k*AW +: AW];

    always_comb begin
      d = regs[a];
      if (BYPASS != 0) begin
        for (int unsigned w = 0; w < 2; w++) begin
          if (RegWrite[w] && rd[w*AW +: AW] == a) d = WriteData[w*XLEN +: XLEN];
        end
      end
      if (!ready_q || (ZERO_REG != 0 && a == '0)) d = '0;
    end

    assign ReadData[k*XLEN +: XLEN] = d;
  end

endmodule

// File: doc/multiport_register_file.md
MULTIPORT_REGISTER_FILE -- requirements
Module: multiport_register_file

Interface
REQ-001 SHALL have parameter XLEN, default 64, meaning register width in bits.
REQ-002 SHALL have parameter NREGS, default 32, meaning register count; power of two, 2 to 256.
REQ-003 SHALL have parameter NRP, default 2, meaning number of read ports; 1 to 4.
REQ-004 SHALL have parameter ZERO_REG, default 1, meaning 1 hardwires register 0 to zero.
REQ-005 SHALL have parameter BYPASS, default 1, meaning 1 forwards same-cycle write data to reads.
REQ-006 SHALL define localparam AW = clog2(NREGS).
REQ-007 SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-008 SHALL have port reset, input, 1 bit, asynchronous active-low reset.
REQ-009 SHALL have port clear_req, input, 1 bit, single-cycle request to re-zero all registers.
REQ-010 SHALL have port rs, input, NRP*AW bits, read addresses; port k at bits [k*AW +: AW].
REQ-011 SHALL have port ReadData, output, NRP*XLEN bits, read data; port k at bits [k*XLEN +: XLEN].
REQ-012 SHALL have port RegWrite, input, 2 bits, per-write-port enable.
REQ-013 SHALL have port rd, input, 2*AW bits, write addresses; port w at bits [w*AW +: AW].
REQ-014 SHALL have port WriteData, input, 2*XLEN bits, write data; port w at bits [w*XLEN +: XLEN].
REQ-015 SHALL have port ready, output, 1 bit; high when the clear sweep is complete and accesses are valid.

Function
REQ-016 SHALL implement a two-state FSM: CLEAR and READY.
REQ-017 In CLEAR, each rising edge SHALL write zero to register[cnt] and increment the AW-bit counter cnt.
REQ-018 CLEAR SHALL go to READY on the edge where cnt == NREGS-1; cnt SHALL wrap to 0.
REQ-019 ready SHALL equal (state == READY), driven from a register with no combinational path.
REQ-020 In READY, clear_req=1 at a rising edge SHALL move the FSM to CLEAR with cnt=0; clear_req in CLEAR SHALL be ignored.
REQ-021 In CLEAR, RegWrite SHALL be ignored and every ReadData port SHALL output 0.
REQ-022 In READY, RegWrite[w]=1 SHALL write WriteData port w into register[rd port w] on the rising edge.
REQ-023 When both write ports target the same address in one cycle, port 1 SHALL win.
REQ-024 When ZERO_REG=1, writes to address 0 SHALL be discarded and reads of address 0 SHALL return 0, including bypass.
REQ-025 Reads SHALL be combinational: ReadData port k = register[rs port k] in the same cycle.
REQ-026 When BYPASS=1, ready=1, and RegWrite[w]=1 with rd port w == rs port k (non-zero address when ZERO_REG=1), ReadData port k SHALL return WriteData port w; port 1 SHALL beat port 0.
REQ-027 When BYPASS=0, reads SHALL return the pre-edge register contents; new data SHALL be visible the cycle after the write.
REQ-028 Out-of-range addresses cannot occur; AW exactly spans NREGS.
REQ-029 clear_req and a write in the same READY cycle: the write SHALL commit, then the sweep SHALL zero it.

Reset
REQ-030 reset=0 SHALL immediately set state=CLEAR, cnt=0, ready=0, and force all ReadData to 0, independent of clk.
REQ-031 The register array SHALL NOT be asynchronously reset; it SHALL be zeroed by the sweep after reset releases.
REQ-032 Reset asserted mid-sweep or mid-write SHALL abort the operation and restart the sweep from cnt=0 on release.
REQ-033 After reset release, ready SHALL rise after exactly NREGS rising edges.

Verification
REQ-034 Defaults: release reset, count edges -> ready=1 after exactly 32 edges; all 32 registers read 0.
REQ-035 Write x5=0xDEAD_BEEF via port 0 with rs port 0 = 5, BYPASS=1 -> ReadData port 0 = 0xDEADBEEF in the same cycle; BYPASS=0 -> old value, then 0xDEADBEEF next cycle.
REQ-036 Both ports write x7 (port 0 = 0x11, port 1 = 0x22) -> x7 reads 0x22 in the next cycle and via bypass in the same cycle.
REQ-037 Write 0xFFFF to x0 with ZERO_REG=1 -> x0 reads 0 in the same cycle and the next; with ZERO_REG=0 -> x0 reads 0xFFFF in the next cycle.
REQ-038 Fill x1..x31, pulse clear_req -> ready=0 next cycle; writes during the sweep are ignored; after 32 edges ready=1 and every register reads 0.
REQ-039 Assert reset at sweep cnt=10 -> ready=0 and ReadData=0 immediately; after release, ready rises after exactly 32 edges.
